kronos_wb: RTL and testbench

KRONOS_WB -- requirements
Module: kronos_WB

---
 rtl/kronos_wb.sv | 169 ++++++++++++++++
 tb/tb_kronos_wb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_wb.sv
// Kronos write-back stage: retires EX results, runs the data-bus load/store handshake,
// raises branch/trap strobes. Define KRONOS_WB_FWD_EN to drive the EX forwarding path.
package kronos_wb_pkg;
  typedef struct packed {
    logic [31:0] result1;
    logic [31:0] result2;
    logic [4:0]  rd;
    logic        rd_write;
    logic        branch;
    logic        branch_cond;
    logic [1:0]  ld_size;
    logic        ld_sign;
    logic        st;
    logic        illegal;
  } pipeEXWB_t;
endpackage

module kronos_wb
  import kronos_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rstz,
  input  pipeEXWB_t   execute,
  input  logic        pipe_in_vld,
  output logic        pipe_in_rdy,
  output logic [31:0] regwr_data,
  output logic [4:0]  regwr_sel,
  output logic        regwr_en,
  output logic [31:0] branch_target,
  output logic        branch,
  output logic        trap,
  output logic [31:0] fwd_data,
  output logic        fwd_vld,
  output logic [31:0] data_addr,
  input  logic [31:0] data_rd_data,
  output logic [31:0] data_wr_data,
  output logic [3:0]  data_mask,
  output logic        data_wr_en,
  output logic        data_req,
  input  logic        data_ack
);
  localparam int DATA_W = 32;

  typedef enum logic {STEADY, MEM} state_t;
  state_t state_p1, state_nxt;

  logic       xfer, is_ill, is_st, is_ld, is_mem, alu_wr, take_br, ack_mem;
  logic [4:0] mem_rd_p1;
  logic [1:0] mem_size_p1, mem_off_p1;
  logic       mem_sign_p1;

  // Bring the addressed lane down to bit 0, then sign- or zero-extend by access size.
  function automatic logic [DATA_W-1:0] load_align(input logic [31:0] raw,
                                                   input logic [1:0]  off,
                                                   input logic [1:0]  size,
                                                   input logic        sgn);
    logic [31:0]        sh;
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic signed [31:0] ext;
    sh  = raw >> {off, 3'b000};
    b8  = sh[7:0];
    h16 = sh[15:0];
    case (size)
      2'b00:   if (sgn) ext = 32'(b8);  else ext = {24'd0, sh[7:0]};
      2'b01:   if (sgn) ext = 32'(h16); else ext = {16'd0, sh[15:0]};
      default: ext = sh;
    endcase
    return ext;
  endfunction

  // Returns {byte-enable mask, lane-replicated store data}.
  function automatic logic [35:0] store_lane(input logic [31:0] d,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size);
    logic [35:0] r;
    case (size)
      2'b00:   r = {4'b0001 << off, {4{d[7:0]}}};
      2'b01:   r = {4'b0011 << {off[1], 1'b0}, {2{d[15:0]}}};
      default: r = {4'b1111, d};
    endcase
    return r;
  endfunction

  assign pipe_in_rdy = (state_p1 == STEADY);
  assign data_req    = (state_p1 == MEM);
  assign xfer        = pipe_in_vld & pipe_in_rdy;
  assign ack_mem     = data_req & data_ack;

  // Illegal instructions neutralise every other side effect of the bundle.
  assign is_ill  = execute.illegal;
  assign is_st   = execute.st & ~is_ill;
  assign is_ld   = ~is_ill & ~execute.st & execute.rd_write & (execute.ld_size != 2'b11);
  assign is_mem  = is_st | is_ld;
  assign alu_wr  = ~is_ill & ~execute.st & ~is_ld & execute.rd_write & (execute.rd != 5'd0);
  assign take_br = ~is_ill & (execute.branch | (execute.branch_cond & execute.result1[0]));

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) state_p1 <= STEADY;
    else       state_p1 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      STEADY: if (xfer & is_mem) state_nxt = MEM;
      MEM:    if (data_ack)      state_nxt = STEADY;
    endcase
  end

  // Stage p1: register-file write, branch and trap strobes
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      regwr_en      <= 1'b0;
      regwr_sel     <= '0;
      regwr_data    <= '0;
      branch        <= 1'b0;
      branch_target <= '0;
      trap          <= 1'b0;
    end else begin
      regwr_en <= (xfer & alu_wr) | (ack_mem & ~data_wr_en & (mem_rd_p1 != 5'd0));
      branch   <= xfer & take_br;
      trap     <= xfer & is_ill;
      if (xfer & alu_wr) begin
        regwr_sel  <= execute.rd;
        regwr_data <= execute.result1;
      end else if (ack_mem & ~data_wr_en) begin
        regwr_sel  <= mem_rd_p1;
        regwr_data <= load_align(data_rd_data, mem_off_p1, mem_size_p1, mem_sign_p1);
      end
      if (xfer & take_br) branch_target <= execute.result2;
    end
  end

  // Stage p1: data-bus request, held stable until acknowledged
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      data_addr    <= '0;
      data_wr_data <= '0;
      data_mask    <= '0;
      data_wr_en   <= 1'b0;
      mem_rd_p1    <= '0;
      mem_size_p1  <= '0;
      mem_off_p1   <= '0;
      mem_sign_p1  <= 1'b0;
    end else if (xfer & is_mem) begin
      data_addr  <= {execute.result1[31:2], 2'b00};
      data_wr_en <= is_st;
      {data_mask, data_wr_data} <= is_st
        ? store_lane(execute.result2, execute.result1[1:0], execute.ld_size)
        : {4'b1111, 32'd0};
      mem_rd_p1   <= execute.rd;
      mem_size_p1 <= execute.ld_size;
      mem_off_p1  <= execute.result1[1:0];
      mem_sign_p1 <= execute.ld_sign;
    end else if (ack_mem) begin
      data_wr_en <= 1'b0;
    end
  end

`ifdef KRONOS_WB_FWD_EN
  assign fwd_vld  = regwr_en;
  assign fwd_data = regwr_data;
`else
  assign fwd_vld  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_kronos_wb.sv
// Scoreboard bench for kronos_wb: driver pushes expected events, negedge monitor pops and compares.
module tb_kronos_wb;
  import kronos_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rstz = 1'b0;
  pipeEXWB_t   execute;
  logic        pipe_in_vld = 1'b0;
  logic        pipe_in_rdy;
  logic [31:0] regwr_data;
  logic [4:0]  regwr_sel;
  logic        regwr_en;
  logic [31:0] branch_target;
  logic        branch;
  logic        trap;
  logic [31:0] fwd_data;
  logic        fwd_vld;
  logic [31:0] data_addr;
  logic [31:0] data_rd_data = 32'd0;
  logic [31:0] data_wr_data;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic        data_ack = 1'b0;

  kronos_wb dut (
    .clk(clk), .rstz(rstz), .execute(execute), .pipe_in_vld(pipe_in_vld),
    .pipe_in_rdy(pipe_in_rdy), .regwr_data(regwr_data), .regwr_sel(regwr_sel),
    .regwr_en(regwr_en), .branch_target(branch_target), .branch(branch), .trap(trap),
    .fwd_data(fwd_data), .fwd_vld(fwd_vld), .data_addr(data_addr),
    .data_rd_data(data_rd_data), .data_wr_data(data_wr_data), .data_mask(data_mask),
    .data_wr_en(data_wr_en), .data_req(data_req), .data_ack(data_ack)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] sel; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] mask; int cycles; } bus_t;

  wr_t         q_wr[$];
  logic [31:0] q_br[$];
  int          q_trap[$];
  bus_t        q_bus[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference model: plain arithmetic on the architectural rules.
  function automatic logic [31:0] model_load(input logic [31:0] raw, input int off,
                                             input int size, input bit sgn);
    longint v, lim;
    int nb;
    nb  = (size == 0) ? 8 : (size == 1) ? 16 : 32;
    v   = longint'({32'd0, raw}) >> (8 * off);
    lim = longint'(1) << nb;
    v   = v % lim;
    if (sgn && v >= lim / 2) v = v - lim;
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_mask(input int off, input int size);
    int m;
    if (size == 0)      m = 1 << off;
    else if (size == 1) m = 3 << ((off / 2) * 2);
    else                m = 15;
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input int size);
    longint v;
    if (size == 0)      v = longint'(d % 256) * 64'h01010101;
    else if (size == 1) v = longint'(d % 65536) * 64'h00010001;
    else                v = longint'(d);
    return v[31:0];
  endfunction

  function automatic pipeEXWB_t mk(input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [4:0] rd, input logic rdw, input logic br,
                                   input logic brc, input logic [1:0] sz, input logic sgn,
                                   input logic stv, input logic ill);
    pipeEXWB_t e;
    e.result1 = r1; e.result2 = r2; e.rd = rd; e.rd_write = rdw; e.branch = br;
    e.branch_cond = brc; e.ld_size = sz; e.ld_sign = sgn; e.st = stv; e.illegal = ill;
    return e;
  endfunction

  task automatic issue(input pipeEXWB_t e, input int dly, input logic [31:0] rdv);
    bit ill, st, ld;
    int w, off, sz;
    bus_t b;
    ill = e.illegal;
    st  = e.st && !ill;
    ld  = !ill && !e.st && e.rd_write && (e.ld_size != 2'b11);
    off = int'(e.result1[1:0]);
    sz  = int'(e.ld_size);
    w = 0;
    while (!pipe_in_rdy && w < 50) begin @(posedge clk); #1; w++; end
    if (!pipe_in_rdy) begin check("rdy_timeout", 32'(pipe_in_rdy), 32'd1); return; end
    if (ill) q_trap.push_back(1);
    else begin
      if (e.branch || (e.branch_cond && e.result1[0])) q_br.push_back(e.result2);
      if (st || ld) begin
        b.addr = e.result1 - (e.result1 % 4);
        b.we = st;
        b.wdata = st ? model_wdata(e.result2, sz) : 32'd0;
        b.mask = st ? model_mask(off, sz) : 4'hF;
        b.cycles = dly + 1;
        q_bus.push_back(b);
      end
      if (ld && e.rd != 0) q_wr.push_back('{e.rd, model_load(rdv, off, sz, e.ld_sign)});
      if (!st && !ld && e.rd_write && e.rd != 0) q_wr.push_back('{e.rd, e.result1});
    end
    execute = e;
    pipe_in_vld = 1'b1;
    @(posedge clk); #1;
    pipe_in_vld = 1'b0;
    execute = mk($urandom, $urandom, 5'($urandom_range(0, 31)), 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
    if (st || ld) begin
      repeat (dly) begin @(posedge clk); #1; end
      data_rd_data = rdv;
      data_ack = 1'b1;
      @(posedge clk); #1;
      data_ack = 1'b0;
      data_rd_data = $urandom;
    end
  endtask

  // Monitor: consumes expected events whenever the DUT presents a strobe or bus request.
  wr_t  mw;
  bus_t cur;
  bit   active = 0;
  int   cyc = 0;
  always @(negedge clk) begin
    if (!rstz) begin
      active = 0;
      cyc = 0;
    end else begin
      if (regwr_en) begin
        if (q_wr.size() == 0) check("unexpected_regwr", 32'(regwr_en), 32'd0);
        else begin
          mw = q_wr.pop_front();
          check("regwr_sel", 32'(regwr_sel), 32'(mw.sel));
          check("regwr_data", regwr_data, mw.data);
`ifdef KRONOS_WB_FWD_EN
          check("fwd_vld", 32'(fwd_vld), 32'd1);
          check("fwd_data", fwd_data, mw.data);
`else
          check("fwd_vld", 32'(fwd_vld), 32'd0);
          check("fwd_data", fwd_data, 32'd0);
`endif
        end
      end
      if (branch) begin
        if (q_br.size() == 0) check("unexpected_branch", 32'(branch), 32'd0);
        else check("branch_target", branch_target, q_br.pop_front());
      end
      if (trap) begin
        if (q_trap.size() == 0) check("unexpected_trap", 32'(trap), 32'd0);
        else void'(q_trap.pop_front());
      end
      if (data_req) begin
        if (!active) begin
          if (q_bus.size() == 0) check("unexpected_req", 32'(data_req), 32'd0);
          else begin cur = q_bus.pop_front(); active = 1; cyc = 0; end
        end
        if (active) begin
          cyc++;
          check("bus_addr", data_addr, cur.addr);
          check("bus_wr_en", 32'(data_wr_en), 32'(cur.we));
          check("bus_mask", 32'(data_mask), 32'(cur.mask));
          if (cur.we) check("bus_wdata", data_wr_data, cur.wdata);
        end
      end else if (active) begin
        check("req_cycles", 32'(cyc), 32'(cur.cycles));
        active = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pipeEXWB_t e;
    bus_t b;
    bit ill, st;
    logic [1:0] sz;
    execute = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", 32'(pipe_in_rdy), 32'd1);
    check("rst_regwr_en", 32'(regwr_en), 32'd0);
    check("rst_branch", 32'(branch), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_req", 32'(data_req), 32'd0);
    check("rst_wr_en", 32'(data_wr_en), 32'd0);
    check("rst_fwd_vld", 32'(fwd_vld), 32'd0);
    check("rst_regwr_data", regwr_data, 32'd0);
    check("rst_regwr_sel", 32'(regwr_sel), 32'd0);
    check("rst_branch_target", branch_target, 32'd0);
    check("rst_addr", data_addr, 32'd0);
    check("rst_wdata", data_wr_data, 32'd0);
    check("rst_mask", 32'(data_mask), 32'd0);
    check("rst_fwd_data", fwd_data, 32'd0);
    rstz = 1'b1;
    @(posedge clk); #1;

    issue(mk(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0), 0, 32'h0);
    issue(mk(32'h103, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0), 3, 32'h80FFFFFF);
    issue(mk(32'h202, 32'hABCD, 5'd3, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0), 1, 32'h0);
    issue(mk(32'h1, 32'h400, 5'd0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0), 0, 32'h0);
    issue(mk(32'h0, 32'h400, 5'd0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0), 0, 32'h0);
    issue(mk(32'h5, 32'h6, 5'd9, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1), 0, 32'h0);
    issue(mk(32'h55, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0), 0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      ill = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 3) == 0);
      sz  = st ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
      e = mk($urandom, $urandom, 5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), sz,
             1'($urandom_range(0, 1)), st, ill);
      issue(e, int'($urandom_range(0, 4)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        data_rd_data = $urandom;
        data_ack = 1'b1;
        @(posedge clk); #1;
        data_ack = 1'b0;
      end
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end

    // Reset while a load is outstanding: request drops at once, load is discarded.
    e = mk(32'h310, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    b.addr = 32'h310; b.we = 1'b0; b.wdata = 32'd0; b.mask = 4'hF; b.cycles = 0;
    q_bus.push_back(b);
    execute = e;
    pipe_in_vld = 1'b1;
    @(posedge clk); #1;
    pipe_in_vld = 1'b0;
    @(posedge clk); #2;
    rstz = 1'b0;
    #1;
    check("mem_rst_req", 32'(data_req), 32'd0);
    check("mem_rst_rdy", 32'(pipe_in_rdy), 32'd1);
    check("mem_rst_addr", data_addr, 32'd0);
    check("mem_rst_wr_en", 32'(data_wr_en), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstz = 1'b1;
    data_rd_data = 32'hDEADBEEF;
    data_ack = 1'b1;
    @(posedge clk); #1;
    data_ack = 1'b0;
    check("post_rst_rdy", 32'(pipe_in_rdy), 32'd1);
    check("post_rst_req", 32'(data_req), 32'd0);
    issue(mk(32'hCAFE, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0), 0, 32'h0);

    repeat (5) @(posedge clk);
    #1;
    check("pending_regwr", 32'(q_wr.size()), 32'd0);
    check("pending_branch", 32'(q_br.size()), 32'd0);
    check("pending_trap", 32'(q_trap.size()), 32'd0);
    check("pending_bus", 32'(q_bus.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
